// File: rtl/rr_arbiter_8_pkg.sv
// arb_pkg: shared sizes and state encoding for the round-robin arbiter
package arb_pkg;
    localparam int NUM_CH = 8;
    localparam int IDX_W = 3;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: request/grant bus between the clients and the arbiter
interface rr_arbiter_8_if;
    import arb_pkg::*;
    logic [NUM_CH-1:0] req;
    logic done;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic grant_valid;
    logic timeout;
    modport master (output req, done, input grant, grant_idx, grant_valid, timeout);
    modport slave (input req, done, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/rr_arbiter_8_idx_to_onehot.sv
// idx_to_onehot: binary index to one-hot select
module idx_to_onehot import arb_pkg::*; (
    input  logic [IDX_W-1:0]  idx,
    output logic [NUM_CH-1:0] onehot
);
    assign onehot = NUM_CH'(1) << idx;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with done/drop/timeout release
module rr_arbiter_8 import arb_pkg::*; #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W = 8
) (
    input logic           clk,
    input logic           rst,
    rr_arbiter_8_if.slave bus
);
    logic [0:0] state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0] grant_q, grant_d, win_oh;
    logic timeout_q, timeout_d, any_req, expire, rel, busy;
    idx_to_onehot u_oh (.idx(win), .onehot(win_oh));
    // walk from the farthest slot back to ptr so the nearest requester wins
    always_comb begin
        win = ptr_q;
        for (int k = NUM_CH - 1; k >= 0; k--)
            win = bus.req[ptr_q + IDX_W'(k)] ? ptr_q + IDX_W'(k) : win;
        busy = state_q == GRANT;
        any_req = |bus.req;
        expire = cnt_q == HOLD_W'(MAX_HOLD - 1);
        rel = bus.done || !bus.req[idx_q] || expire;
        state_d = busy ? (rel ? IDLE : GRANT) : (any_req ? GRANT : IDLE);
        idx_d = (!busy && any_req) ? win : idx_q;
        grant_d = (state_d == IDLE) ? '0 : (busy ? grant_q : win_oh);
        cnt_d = busy ? cnt_q + HOLD_W'(1) : '0;
        ptr_d = (busy && rel) ? idx_q + IDX_W'(1) : ptr_q;
        timeout_d = busy && expire && !bus.done && bus.req[idx_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            grant_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            grant_q <= grant_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.grant = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.grant_valid = busy;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed and random checks of rr_arbiter_8 against a behavioural model
module tb_rr_arbiter_8;
    localparam int MH = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    rr_arbiter_8_if bus();
    rr_arbiter_8 #(.MAX_HOLD(MH), .HOLD_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // model: owner=-1 when idle, age = cycles the current grant has been visible
    int owner = -1;
    int ptr = 0;
    int age = 0;
    logic [2:0] m_idx = 3'd0;
    bit m_to = 1'b0;
    bit armed = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            owner = -1;
            ptr = 0;
            age = 0;
            m_idx = 3'd0;
            m_to = 1'b0;
        end else if (owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 8; k++)
                if (owner < 0 && bus.req[(ptr + k) % 8]) owner = (ptr + k) % 8;
            if (owner >= 0) begin
                m_idx = 3'(owner);
                age = 1;
            end
        end else begin
            m_to = (age == MH) && !bus.done && bus.req[owner];
            if (bus.done || !bus.req[owner] || age == MH) begin
                ptr = (owner + 1) % 8;
                owner = -1;
            end else age++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_grant", bus.grant, (owner < 0) ? 0 : (1 << owner));
            chk("m_valid", bus.grant_valid, owner >= 0);
            chk("m_idx", bus.grant_idx, m_idx);
            chk("m_timeout", bus.timeout, m_to);
        end
    end

    task automatic wait_grant(input string nm, input logic [7:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grant == 8'h00 && n < 40);
        chk(nm, bus.grant, exp);
    endtask

    initial begin
        int n;
        int dp;
        bus.req = 8'hFF;
        bus.done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_grant", bus.grant, 0);
            chk("rst_valid", bus.grant_valid, 0);
            chk("rst_idx", bus.grant_idx, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", bus.grant, 8'h01);
        bus.req = 8'h00;
        @(negedge clk);
        chk("first_rel", bus.grant, 0);
        bus.req = 8'h10;
        wait_grant("single", 8'h10);
        chk("single_idx", bus.grant_idx, 4);
        repeat (2) begin
            @(negedge clk);
            chk("single_hold", bus.grant, 8'h10);
        end
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        chk("single_rel", bus.grant, 0);
        @(negedge clk);
        chk("single_regrant", bus.grant, 8'h10);
        bus.req = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_grant("rr_seq", 8'(1 << (i % 8)));
            bus.done = 1'b1;
            @(negedge clk);
            bus.done = 1'b0;
            chk("rr_gap", bus.grant, 0);
        end
        bus.req = 8'h40;
        wait_grant("skip6", 8'h40);
        bus.req = 8'h00;
        @(negedge clk);
        bus.req = 8'b0100_0101;
        wait_grant("skip0", 8'h01);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        wait_grant("skip2", 8'h04);
        bus.req = 8'h00;
        @(negedge clk);
        bus.req = 8'h02;
        wait_grant("to_grant", 8'h02);
        n = 1;
        @(negedge clk);
        while (bus.grant == 8'h02 && n < 40) begin
            chk("to_early", bus.timeout, 0);
            n++;
            @(negedge clk);
        end
        chk("to_len", n, MH);
        chk("to_pulse", bus.timeout, 1);
        bus.req = 8'h05;
        @(negedge clk);
        chk("to_once", bus.timeout, 0);
        chk("to_ptr", bus.grant, 8'h04);
        bus.req = 8'h00;
        @(negedge clk);
        bus.req = 8'h08;
        wait_grant("drop_grant", 8'h08);
        @(negedge clk);
        bus.req = 8'h00;
        @(negedge clk);
        chk("drop_rel", bus.grant, 0);
        chk("drop_to", bus.timeout, 0);
        bus.req = 8'h08;
        wait_grant("exp_grant", 8'h08);
        repeat (15) @(negedge clk);
        chk("exp_hold", bus.grant, 8'h08);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        chk("exp_rel", bus.grant, 0);
        chk("exp_to", bus.timeout, 0);
        wait_grant("rst_mid_grant", 8'h08);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 8'h00;
        chk("rst_mid_rel", bus.grant, 0);
        chk("rst_mid_to", bus.timeout, 0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            dp = ((i / 500) % 2 == 1) ? 40 : 4;
            if ($urandom_range(0, 3) == 0)
                bus.req = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            bus.done = $urandom_range(0, dp - 1) == 0;
            rst = $urandom_range(0, 299) == 0;
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester round-robin arbiter for a single shared resource.
- Resolves the winner to a 3-bit index and drives a one-hot select derived from that index.
- Grants are held until the owner signals completion, drops its request, or hits a hold timeout.
- Sits between up to eight client blocks and one shared resource, e.g. a bus, display port or memory.

Parameters:
- MAX_HOLD, 16: maximum cycles one grant may last before forced release; legal range 2..255.
- HOLD_W, 8: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = client i wants the resource.
- done  input  1  the current owner has finished; sampled only in GRANT.
- grant  output  8  one-hot grant; all zero when no owner.
- grant_idx  output  3  binary index of the owner; valid only while grant_valid=1.
- grant_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD.

Behaviour:
- Reset, sampled at a clk edge with rst=1, sets:
  - state=IDLE, grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0;
  - priority pointer ptr=3'd0, hold counter=0.
- rst dominates every other input.
- Reset mid-grant drops grant on the next edge. No done or timeout is emitted for the aborted grant.
- State IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ..., ptr+7, with indices wrapping modulo 8.
  - On the next edge: grant_idx=winner, grant=one-hot(winner), grant_valid=1, hold counter=0, state -> GRANT.
  - Latency is exactly 1 cycle from req sampled to grant visible.
- State GRANT:
  - Hold counter increments every cycle.
  - Release conditions, evaluated in one cycle:
    - (a) done=1;
    - (b) req[grant_idx]=0;
    - (c) hold counter = MAX_HOLD-1.
  - On release, at the next edge: grant=0, grant_valid=0, ptr=grant_idx+1 (3-bit wrap, 7 -> 0), state -> IDLE.
  - timeout=1 for that single cycle only when (c) holds and neither (a) nor (b) holds. If done arrives in the same cycle as expiry, it is a normal release with no timeout.
- Grant spacing:
  - There is at least one idle cycle between consecutive grants, including back-to-back requesters.
  - Grant duration is 1..MAX_HOLD cycles.
- Other requesters' req bits changing during GRANT have no effect.
- done sampled in IDLE is ignored.
- Fairness: with all 8 requesting continuously, grants go 0,1,2,...,7,0 in order, with no starvation.
- grant is always one-hot or zero, and equals one-hot(grant_idx) whenever grant_valid=1.
- All outputs are registered. There is no combinational path from req or done to any output.

Decomposition:
- Shared package arb_pkg:
  - NUM_CH=8, IDX_W=3;
  - state encoding IDLE=1'b0, GRANT=1'b1.
- One sub-module, idx_to_onehot:
  - pure combinational 3-to-8 binary-to-one-hot converter;
  - drives the next-state grant vector from the selected index.
- Rotating priority search stays in the top level.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with req=8'hFF -> grant=8'h00, grant_valid=0, grant_idx=0. After release, first grant is client 0 one cycle later.
- Single requester: req=8'h10 held, done pulsed 3 cycles after grant -> grant=8'h10, grant_idx=4, held exactly 3 cycles, then 8'h00 for ≥1 cycle, then regranted to client 4.
- Round-robin wrap: req=8'hFF constant, each owner pulses done 1 cycle after grant -> grant sequence 8'h01,8'h02,...,8'h80,8'h01 with one zero cycle between each.
- Pointer skip: grant client 6, release, then req=8'b0100_0101 -> next grant is client 0 (ptr=7, search 7,0). The following grant is client 2.
- Timeout: MAX_HOLD=16, req=8'h02 held, done never asserted -> grant=8'h02 for exactly 16 cycles. timeout=1 on the release cycle only, and ptr=2.
- Request drop and simultaneous events:
  - Owner 3 deasserts req mid-grant -> release the next edge with timeout=0.
  - done and expiry in the same cycle -> release with timeout=0.
  - rst asserted mid-grant -> grant=8'h00 the next edge.
